// File: rtl/smc_pkg.sv
// Shared register map, status codes and command FSM encoding for smc_ctrl.
package smc_pkg;

  localparam logic [7:0] REG_KBD_BUF   = 8'h07;
  localparam logic [7:0] REG_KBD_COUNT = 8'h0A;
  localparam logic [7:0] REG_KBD_FLAGS = 8'h0B;
  localparam logic [7:0] REG_KBD_STAT  = 8'h18;
  localparam logic [7:0] REG_KBD_CMD   = 8'h19;

  localparam logic [7:0] STAT_NONE = 8'h00;  // no command issued yet
  localparam logic [7:0] STAT_PEND = 8'h01;  // command accepted, in flight
  localparam logic [7:0] STAT_ACK  = 8'hFA;
  localparam logic [7:0] STAT_NACK = 8'hFE;
  localparam logic [7:0] STAT_TMO  = 8'hFD;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_WAIT = 2'd1,  // command latched, waiting for PS2 port to go idle
    CMD_SENT = 2'd2   // command handed to PS2 port, awaiting ACK/NACK
  } cmd_state_e;

endpackage

// File: rtl/smc_ctrl_if.sv
// I2C-slave byte bus, keyboard code input and PS2 command port of smc_ctrl.
interface smc_ctrl_if;
  logic       devsel;
  logic       rw_bit;
  logic [7:0] rxbyte;
  logic       rxbyte_v;
  logic [7:0] txbyte;
  logic       txbyte_deq;
  logic [7:0] kbd_code;
  logic       kbd_code_v;
  logic [7:0] cmd_tx;
  logic       cmd_tx_v;
  logic       ps2_busy;
  logic       tx_acked;
  logic       tx_errd;

  modport slave (
    input  devsel, rw_bit, rxbyte, rxbyte_v, txbyte_deq,
    input  kbd_code, kbd_code_v, ps2_busy, tx_acked, tx_errd,
    output txbyte, cmd_tx, cmd_tx_v
  );

  modport master (
    output devsel, rw_bit, rxbyte, rxbyte_v, txbyte_deq,
    output kbd_code, kbd_code_v, ps2_busy, tx_acked, tx_errd,
    input  txbyte, cmd_tx, cmd_tx_v
  );
endinterface

// File: rtl/smc_ctrl_fifo.sv
// Show-ahead synchronous FIFO; a push while full only lands if a pop frees a slot.
module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(2**AW));
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset; contents are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/smc_ctrl.sv
// System management controller: I2C register file over a keyboard code FIFO
// and a PS2 command sequencer with ACK/NACK/timeout status.
module smc_ctrl
  import smc_pkg::*;
#(
  parameter int FIFO_AW        = 4,
  parameter int CMD_TIMEOUT_US = 20000
) (
  input  logic     clk6x,
  input  logic     resetn,
  input  logic     ck1us,
  smc_ctrl_if.slave bus
);
  localparam int TW = $clog2(CMD_TIMEOUT_US + 1);

  logic [1:0]     idx_q, idx_d;
  logic [7:0]     regnum_q, regnum_d;
  logic [7:0]     txbyte_q, txbyte_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     rd_data;
  cmd_state_e     state_q, state_d;
  logic [7:0]     stat_q, stat_d;
  logic [7:0]     cmd_tx_q, cmd_tx_d;
  logic           cmd_v_q, cmd_v_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic [7:0]     head;
  logic [FIFO_AW:0] count;
  logic           full, empty;
  logic           deq, wr_data, fifo_pop, ovf_set;

  assign deq      = bus.devsel && bus.txbyte_deq;
  assign wr_data  = bus.devsel && bus.rxbyte_v && (idx_q == 2'd1);
  assign fifo_pop = deq && (regnum_q == REG_KBD_BUF);
  // A pop in the same cycle makes room, so the code is kept.
  assign ovf_set  = bus.kbd_code_v && full && !fifo_pop;

  sync_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk     (clk6x),
    .resetn  (resetn),
    .push_i  (bus.kbd_code_v),
    .pop_i   (fifo_pop),
    .din_i   (bus.kbd_code),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Read mux for the register selected by regnum.
  always_comb begin
    rd_data = 8'hFF;
    case (regnum_q)
      REG_KBD_BUF:   rd_data = empty ? 8'h00 : head;
      REG_KBD_COUNT: rd_data = 8'(count);
      REG_KBD_FLAGS: rd_data = {5'b0, full, empty, ovf_q};
      REG_KBD_STAT:  rd_data = stat_q;
      default:       rd_data = 8'hFF;
    endcase
  end

  // I2C byte indexing, register select, read data and overflow flag.
  always_comb begin
    idx_d    = idx_q;
    regnum_d = regnum_q;
    txbyte_d = txbyte_q;
    ovf_d    = ovf_q;
    if (!bus.devsel)
      idx_d = 2'd0;
    else if ((bus.rxbyte_v || bus.txbyte_deq) && idx_q != 2'd3)
      idx_d = idx_q + 2'd1;
    if (bus.devsel && bus.rxbyte_v && idx_q == 2'd0) regnum_d = bus.rxbyte;
    if (bus.devsel && bus.rw_bit) txbyte_d = rd_data;
    // A new overflow beats the read-to-clear in the same cycle.
    if (ovf_set)                                 ovf_d = 1'b1;
    else if (deq && regnum_q == REG_KBD_FLAGS)   ovf_d = 1'b0;
  end

  // Command FSM: latch, wait for idle port, send, then collect the result.
  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    cmd_tx_d = cmd_tx_q;
    cmd_v_d  = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      CMD_IDLE: if (wr_data && regnum_q == REG_KBD_CMD) begin
        cmd_tx_d = bus.rxbyte;
        stat_d   = STAT_PEND;
        state_d  = CMD_WAIT;
      end
      CMD_WAIT: if (!bus.ps2_busy) begin
        cmd_v_d = 1'b1;
        tmo_d   = '0;
        state_d = CMD_SENT;
      end
      CMD_SENT: begin
        if (bus.tx_errd) begin
          stat_d  = STAT_NACK;
          state_d = CMD_IDLE;
        end else if (bus.tx_acked) begin
          stat_d  = STAT_ACK;
          state_d = CMD_IDLE;
        end else if (ck1us) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(CMD_TIMEOUT_US)) begin
            stat_d  = STAT_TMO;
            state_d = CMD_IDLE;
          end
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      idx_q    <= 2'd0;
      regnum_q <= 8'h00;
      txbyte_q <= 8'hFF;
      ovf_q    <= 1'b0;
      state_q  <= CMD_IDLE;
      stat_q   <= STAT_NONE;
      cmd_tx_q <= 8'h00;
      cmd_v_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      regnum_q <= regnum_d;
      txbyte_q <= txbyte_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      stat_q   <= stat_d;
      cmd_tx_q <= cmd_tx_d;
      cmd_v_q  <= cmd_v_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.txbyte   = txbyte_q;
  assign bus.cmd_tx   = cmd_tx_q;
  assign bus.cmd_tx_v = cmd_v_q;
endmodule

// File: tb/tb_smc_ctrl.sv
// Scoreboard bench for smc_ctrl: stimulus queues expected read bytes, command
// pulses and static probes; the monitor compares whenever the DUT presents them.
module tb_smc_ctrl;
  logic clk6x = 1'b0;
  logic resetn = 1'b0;
  logic ck1us = 1'b0;

  smc_ctrl_if bus();

  smc_ctrl #(.FIFO_AW(4), .CMD_TIMEOUT_US(10)) dut (
    .clk6x  (clk6x),
    .resetn (resetn),
    .ck1us  (ck1us),
    .bus    (bus.slave)
  );

  always #5 clk6x = ~clk6x;

  typedef struct { string nm; logic [7:0] v; } exp_t;
  typedef struct { string nm; logic chk_tx; logic [7:0] tx; logic [7:0] cmd; logic v; } prb_t;

  exp_t rd_q[$];
  exp_t cmd_q[$];
  prb_t prb_q[$];
  logic probe = 1'b0;
  logic done  = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;
  int   ncyc  = 0;

  // Monitor: all comparisons happen here, mid-cycle.
  always @(negedge clk6x) begin
    exp_t e;
    prb_t p;
    ncyc++;
    if (bus.txbyte_deq) begin
      nvec++;
      if (rd_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_read: got %02h, none expected", bus.txbyte);
      end else begin
        e = rd_q.pop_front();
        if (bus.txbyte !== e.v) begin
          nerr++;
          $display("FAIL %s: txbyte got %02h want %02h", e.nm, bus.txbyte, e.v);
        end
      end
    end
    if (bus.cmd_tx_v) begin
      nvec++;
      if (cmd_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_cmd_tx_v: cmd_tx got %02h, no pulse expected", bus.cmd_tx);
      end else begin
        e = cmd_q.pop_front();
        if (bus.cmd_tx !== e.v) begin
          nerr++;
          $display("FAIL %s: cmd_tx got %02h want %02h", e.nm, bus.cmd_tx, e.v);
        end
      end
    end
    if (probe && prb_q.size() != 0) begin
      p = prb_q.pop_front();
      nvec++;
      if (bus.cmd_tx !== p.cmd || bus.cmd_tx_v !== p.v) begin
        nerr++;
        $display("FAIL %s: cmd_tx/v got %02h/%b want %02h/%b", p.nm, bus.cmd_tx, bus.cmd_tx_v, p.cmd, p.v);
      end
      if (p.chk_tx) begin
        nvec++;
        if (bus.txbyte !== p.tx) begin
          nerr++;
          $display("FAIL %s: txbyte got %02h want %02h", p.nm, bus.txbyte, p.tx);
        end
      end
    end
    if (done || ncyc > 20000) begin
      if (!done) begin
        nerr++;
        $display("FAIL watchdog: cycles got %0d want <= 20000", ncyc);
      end
      nvec++;
      if (rd_q.size() != 0 || cmd_q.size() != 0) begin
        nerr++;
        $display("FAIL leftovers: reads %0d cmds %0d pending, want 0/0", rd_q.size(), cmd_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clk6x);
    #1;
  endtask

  task automatic probe_chk(string nm, logic chk_tx, logic [7:0] tx, logic [7:0] cmd, logic v);
    prb_t p;
    p.nm = nm; p.chk_tx = chk_tx; p.tx = tx; p.cmd = cmd; p.v = v;
    prb_q.push_back(p);
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic push_kbd(logic [7:0] c);
    bus.kbd_code = c; bus.kbd_code_v = 1'b1;
    cyc();
    bus.kbd_code_v = 1'b0;
  endtask

  task automatic set_reg(logic [7:0] r);
    bus.devsel = 1'b1; bus.rw_bit = 1'b0; bus.rxbyte = r; bus.rxbyte_v = 1'b1;
    cyc();
    bus.rxbyte_v = 1'b0; bus.devsel = 1'b0;
    cyc();
  endtask

  task automatic wr_reg(logic [7:0] r, logic [7:0] d);
    bus.devsel = 1'b1; bus.rw_bit = 1'b0; bus.rxbyte = r; bus.rxbyte_v = 1'b1;
    cyc();
    bus.rxbyte = d;
    cyc();
    bus.rxbyte_v = 1'b0; bus.devsel = 1'b0;
    cyc();
  endtask

  task automatic exp_cmd(string nm, logic [7:0] c);
    exp_t e;
    e.nm = nm; e.v = c;
    cmd_q.push_back(e);
  endtask

  task automatic rd_begin(logic [7:0] r);
    set_reg(r);
    bus.devsel = 1'b1; bus.rw_bit = 1'b1;
    cyc(); cyc();
  endtask

  // Consume one byte, optionally with a keyboard push in the same cycle.
  task automatic rd_byte_push(string nm, logic [7:0] v, logic push, logic [7:0] code);
    exp_t e;
    e.nm = nm; e.v = v;
    rd_q.push_back(e);
    bus.txbyte_deq = 1'b1;
    bus.kbd_code = code; bus.kbd_code_v = push;
    cyc();
    bus.txbyte_deq = 1'b0; bus.kbd_code_v = 1'b0;
    cyc(); cyc();
  endtask

  task automatic rd_byte(string nm, logic [7:0] v);
    rd_byte_push(nm, v, 1'b0, 8'h00);
  endtask

  task automatic rd_end();
    bus.devsel = 1'b0; bus.rw_bit = 1'b0;
    cyc();
  endtask

  task automatic rd1(string nm, logic [7:0] r, logic [7:0] v);
    rd_begin(r);
    rd_byte(nm, v);
    rd_end();
  endtask

  task automatic us_pulse();
    ck1us = 1'b1;
    cyc();
    ck1us = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    bus.devsel = 1'b0; bus.rw_bit = 1'b0; bus.rxbyte = 8'h00; bus.rxbyte_v = 1'b0;
    bus.txbyte_deq = 1'b0; bus.kbd_code = 8'h00; bus.kbd_code_v = 1'b0;
    bus.ps2_busy = 1'b0; bus.tx_acked = 1'b0; bus.tx_errd = 1'b0;
    resetn = 1'b0;
    cyc(); cyc(); cyc();
    probe_chk("reset_outputs", 1'b1, 8'hFF, 8'h00, 1'b0);
    resetn = 1'b1;
    cyc();

    // Post-reset register values.
    rd1("stat_initial", 8'h18, 8'h00);
    rd1("count_initial", 8'h0A, 8'h00);
    rd1("flags_initial", 8'h0B, 8'h02);
    rd1("unmapped_reg", 8'h55, 8'hFF);

    // Two codes, drain past empty.
    push_kbd(8'h1C);
    push_kbd(8'h32);
    rd_begin(8'h07);
    rd_byte("buf_first", 8'h1C);
    rd_byte("buf_second", 8'h32);
    rd_byte("buf_empty", 8'h00);
    rd_end();
    rd1("count_after_drain", 8'h0A, 8'h00);

    // 17 pushes into a 16-deep FIFO: last one dropped, overflow sticky.
    for (int i = 0; i < 17; i++) push_kbd(8'(64 + i));
    rd1("count_full", 8'h0A, 8'h10);
    rd1("flags_ovf", 8'h0B, 8'h05);
    rd1("flags_ovf_cleared", 8'h0B, 8'h04);
    rd1("buf_after_ovf", 8'h07, 8'h40);

    // Refill to full, then push and pop together.
    push_kbd(8'h51);
    rd_begin(8'h07);
    rd_byte_push("simul_pop", 8'h41, 1'b1, 8'h52);
    rd_end();
    rd1("count_simul", 8'h0A, 8'h10);
    rd1("flags_simul", 8'h0B, 8'h04);
    rd_begin(8'h07);
    for (int i = 0; i < 14; i++) rd_byte("drain", 8'(66 + i));
    rd_byte("drain_51", 8'h51);
    rd_byte("drain_52", 8'h52);
    rd_byte("drain_empty", 8'h00);
    rd_end();

    // Overflow set while the flags read clears it: set wins.
    for (int i = 0; i < 16; i++) push_kbd(8'(96 + i));
    rd_begin(8'h0B);
    rd_byte("flags_before_race", 8'h04);
    rd_byte_push("flags_race", 8'h04, 1'b1, 8'h70);
    rd_byte("flags_set_wins", 8'h05);
    rd_byte("flags_recleared", 8'h04);
    rd_end();

    // Command held while PS2 busy, then sent and ACKed.
    bus.ps2_busy = 1'b1;
    wr_reg(8'h19, 8'hED);
    repeat (50) cyc();
    rd1("stat_pending", 8'h18, 8'h01);
    exp_cmd("cmd_ed", 8'hED);
    bus.ps2_busy = 1'b0;
    cyc(); cyc(); cyc();
    bus.tx_acked = 1'b1; cyc(); bus.tx_acked = 1'b0;
    rd1("stat_ack", 8'h18, 8'hFA);

    // NACK, then ACK and NACK together.
    exp_cmd("cmd_f4", 8'hF4);
    wr_reg(8'h19, 8'hF4);
    bus.tx_errd = 1'b1; cyc(); bus.tx_errd = 1'b0;
    rd1("stat_nack", 8'h18, 8'hFE);
    exp_cmd("cmd_f2", 8'hF2);
    wr_reg(8'h19, 8'hF2);
    rd1("stat_pending2", 8'h18, 8'h01);
    bus.tx_acked = 1'b1; bus.tx_errd = 1'b1; cyc();
    bus.tx_acked = 1'b0; bus.tx_errd = 1'b0;
    rd1("stat_both", 8'h18, 8'hFE);

    // Timeout after the 10th microsecond strobe; a write while SENT is ignored.
    exp_cmd("cmd_ff", 8'hFF);
    wr_reg(8'h19, 8'hFF);
    for (int i = 0; i < 4; i++) us_pulse();
    wr_reg(8'h19, 8'hAA);
    probe_chk("cmd_hold_in_sent", 1'b0, 8'h00, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) us_pulse();
    rd1("stat_9us", 8'h18, 8'h01);
    us_pulse();
    rd1("stat_timeout", 8'h18, 8'hFD);

    // Reset mid-transaction with a command about to go out.
    bus.ps2_busy = 1'b1;
    wr_reg(8'h19, 8'h11);
    set_reg(8'h0A);
    bus.devsel = 1'b1; bus.rw_bit = 1'b1;
    cyc();
    resetn = 1'b0; bus.ps2_busy = 1'b0;
    cyc();
    probe_chk("reset_mid", 1'b1, 8'hFF, 8'h00, 1'b0);
    resetn = 1'b1;
    cyc(); cyc();
    rd_byte("regnum_reset", 8'hFF);
    rd_end();
    rd1("stat_reset", 8'h18, 8'h00);
    rd1("count_reset", 8'h0A, 8'h00);
    rd1("flags_reset", 8'h0B, 8'h02);
    repeat (5) cyc();

    done = 1'b1;
    cyc(); cyc();
  end
endmodule
